// File: rtl/arbitro_mult_pkg.sv
// Shared definitions for the round-robin multiplier scheduler.
// Provides the FSM state encoding and the default requester count and
// operand width used by arbitro_multiplicador and its picker.
package arbitro_mult_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_W     = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    START = S_START,
    WAIT  = S_WAIT,
    RESP  = S_RESP
  } state_t;

endpackage

// File: rtl/arbitro_rr.sv
// Combinational round-robin picker.
// Ports:
//   Req     - request vector, one bit per requester
//   ptr     - requester index with the highest priority this round
//   gnt     - one-hot grant: first asserted Req at or after ptr (cyclic)
//   idx     - binary index of the granted requester
//   req_any - at least one request is pending
// The ptr register itself lives in the parent.
module arbitro_rr #(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] Req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             req_any
);

  always_comb begin
    int          j;
    logic [IW-1:0] jj;
    logic        found;
    gnt     = '0;
    idx     = '0;
    found   = 1'b0;
    j       = 0;
    jj      = '0;
    req_any = |Req;
    for (int k = 0; k < N_REQ; k++) begin
      // Walk the requesters starting at ptr and wrapping at N_REQ.
      j  = (int'(ptr) + k) % N_REQ;
      jj = IW'(j);
      if (!found && Req[jj]) begin
        found   = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/arbitro_multiplicador.sv
// Round-robin scheduler sharing one sequential shift-add multiplier core
// (St/Idle/Done handshake) between N_REQ requesters.
//
// Ports:
//   Clk, Rst            - clock, synchronous active-high reset
//   Req                 - per-requester request level
//   Multiplicando_In    - packed operand A, slice i for requester i
//   Multiplicador_In    - packed operand B, same packing
//   Ack                 - one-hot 1-cycle pulse, operands of requester i taken
//   Produto_Out         - last product, held until the next result
//   Valid_Out, Valid_Id - 1-cycle result strobe and requester index
//   Busy                - high whenever the FSM is not IDLE
//   Mult_St             - start to the core
//   Mult_Multiplicando  - latched operand A to the core
//   Mult_Multiplicador  - latched operand B to the core
//   Mult_Idle, Mult_Done, Mult_Produto - core status and product
//
// Build option ARB_ZERO_BYPASS_EN: a grant with a zero operand skips the
// core and reports product 0 directly (Ack at t, Valid_Out at t+1).
//
// state | meaning
// IDLE  | waiting for a request (and an idle core for non-bypass grants)
// START | Mult_St high until the core drops Mult_Idle
// WAIT  | waiting for Mult_Done, product captured on it
// RESP  | Valid_Out pulse, ptr advances past the served requester
module arbitro_multiplicador
  import arbitro_mult_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  parameter  int W     = DEF_W,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [N_REQ-1:0]   Req,
  input  logic [N_REQ*W-1:0] Multiplicando_In,
  input  logic [N_REQ*W-1:0] Multiplicador_In,
  output logic [N_REQ-1:0]   Ack,
  output logic [2*W-1:0]     Produto_Out,
  output logic               Valid_Out,
  output logic [IW-1:0]      Valid_Id,
  output logic               Busy,
  output logic               Mult_St,
  output logic [W-1:0]       Mult_Multiplicando,
  output logic [W-1:0]       Mult_Multiplicador,
  input  logic               Mult_Idle,
  input  logic               Mult_Done,
  input  logic [2*W-1:0]     Mult_Produto
);

  state_t state_q, state_d;

  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    id_q;
  logic [N_REQ-1:0] rr_gnt;
  logic [IW-1:0]    rr_idx;
  logic             rr_any;
  logic [W-1:0]     sel_a, sel_b;
  logic             zero_op;
  logic             byp_q;

  logic grant, take_byp, cap, resp_done;

  arbitro_rr #(.N_REQ(N_REQ)) u_rr (
    .Req     (Req),
    .ptr     (ptr_q),
    .gnt     (rr_gnt),
    .idx     (rr_idx),
    .req_any (rr_any)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rr_gnt[i]) begin
        sel_a = Multiplicando_In[i*W +: W];
        sel_b = Multiplicador_In[i*W +: W];
      end
    end
  end

`ifdef ARB_ZERO_BYPASS_EN
  assign zero_op = (sel_a == '0) || (sel_b == '0);

  // byp_q marks the first RESP cycle of a bypass grant: that cycle carries
  // the Ack, so the Valid_Out strobe is held back one cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      byp_q <= 1'b0;
    end else if (take_byp) begin
      byp_q <= 1'b1;
    end else if (state_q == RESP) begin
      byp_q <= 1'b0;
    end
  end
`else
  assign zero_op = 1'b0;
  assign byp_q   = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    take_byp  = 1'b0;
    cap       = 1'b0;
    resp_done = 1'b0;
    Busy      = (state_q != IDLE);
    Mult_St   = 1'b0;
    Valid_Out = 1'b0;
    case (state_q)
      IDLE: begin
        if (rr_any) begin
          if (zero_op) begin
            grant    = 1'b1;
            take_byp = 1'b1;
            state_d  = RESP;
          end else if (Mult_Idle) begin
            grant   = 1'b1;
            state_d = START;
          end
        end
      end
      START: begin
        Mult_St = 1'b1;
        if (!Mult_Idle) state_d = WAIT;
      end
      WAIT: begin
        if (Mult_Done) begin
          cap     = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (!byp_q) begin
          Valid_Out = 1'b1;
          resp_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Ack                <= '0;
      ptr_q              <= '0;
      id_q               <= '0;
      Produto_Out        <= '0;
      Valid_Id           <= '0;
      Mult_Multiplicando <= '0;
      Mult_Multiplicador <= '0;
    end else begin
      Ack <= '0;
      if (grant) begin
        Ack                <= rr_gnt;
        id_q               <= rr_idx;
        Mult_Multiplicando <= sel_a;
        Mult_Multiplicador <= sel_b;
      end
      if (take_byp) begin
        Produto_Out <= '0;
        Valid_Id    <= rr_idx;
      end
      if (cap) begin
        Produto_Out <= Mult_Produto;
        Valid_Id    <= id_q;
      end
      if (resp_done) begin
        ptr_q <= (id_q == IW'(N_REQ - 1)) ? '0 : id_q + IW'(1);
      end
    end
  end

endmodule
